// File: rtl/mux_arb_n.sv
// -----------------------------------------------------------------------------
// mux_arb_n
//
// Parametrised N:1 channel multiplexer with valid/ready handshakes on every
// input channel and on the single output. The output stage is one register
// deep and can reload in the same cycle it drains, so it sustains one beat
// per cycle.
//
// Grant selection:
//   mode = 0 : direct select. The channel named by sel is granted when it is
//              valid. sel values >= NCH never grant.
//   mode = 1 : round-robin. The search starts at rr_ptr and moves upward,
//              wrapping at NCH. rr_ptr moves past a channel when that
//              channel's last beat is accepted, in either mode.
//
// Once a channel has a beat accepted without its last flag, the arbiter locks
// onto that channel. Only that channel can be granted until its last beat is
// accepted. While locked, mode and sel are ignored and other channels stall,
// even when the locked channel has a gap in its valid.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   din        : flattened channel data, channel i at [i*DLEN +: DLEN]
//   din_valid  : per-channel valid
//   din_last   : per-channel last-beat flag, used only on an accepted beat
//   din_ready  : per-channel ready, combinational, at most one bit set
//   mode       : 0 = direct select, 1 = round-robin
//   sel        : channel index used in direct-select mode
//   dout       : registered output data
//   dout_ch    : registered index of the channel that supplied dout
//   dout_last  : registered last flag of the beat in dout
//   dout_valid : registered output valid
//   dout_ready : downstream ready
// -----------------------------------------------------------------------------
module mux_arb_n #(
    parameter  int DLEN = 32,
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*DLEN-1:0] din,
    input  logic [NCH-1:0]      din_valid,
    input  logic [NCH-1:0]      din_last,
    output logic [NCH-1:0]      din_ready,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    output logic [DLEN-1:0]     dout,
    output logic [SELW-1:0]     dout_ch,
    output logic                dout_last,
    output logic                dout_valid,
    input  logic                dout_ready
);

    // Arbiter state. IDLE picks a new channel each beat. LOCKED stays on
    // lock_ch until that channel's last beat is accepted.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] lock_ch;

    // Candidate channel for this cycle and whether it has a beat to offer.
    logic [SELW-1:0] cand;
    logic            cand_valid;
    int              rr_idx;

    // Output stage may take a new beat when empty, or when it is draining
    // this cycle.
    logic            load;
    logic            grant;
    logic [SELW-1:0] rr_next;

    // Channel data unpacked for clean indexing by channel number.
    logic [DLEN-1:0] ch_data [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign ch_data[g] = din[g*DLEN +: DLEN];
    end

    assign load = ~dout_valid | dout_ready;

    // ---------------------------------------------------------------------
    // Candidate selection
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // can leave it unassigned and no latch is inferred.
        cand       = '0;
        cand_valid = 1'b0;
        rr_idx     = 0;

        if (state == LOCKED) begin
            cand       = lock_ch;
            cand_valid = din_valid[lock_ch];
        end else if (!mode) begin
            cand = sel;
            // sel can exceed NCH-1 only when NCH is not a power of two.
            if (int'(sel) < NCH) begin
                cand_valid = din_valid[sel];
            end
        end else begin
            // Scan from the farthest offset down to offset 0. The last hit
            // wins, so the lowest offset from rr_ptr takes priority.
            for (int k = NCH - 1; k >= 0; k--) begin
                rr_idx = int'(rr_ptr) + k;
                if (rr_idx >= NCH) begin
                    rr_idx = rr_idx - NCH;
                end
                if (din_valid[SELW'(rr_idx)]) begin
                    cand       = SELW'(rr_idx);
                    cand_valid = 1'b1;
                end
            end
        end
    end

    // Reset has priority over every event, so no handshake completes while
    // it is asserted.
    assign grant = ~rst & load & cand_valid;

    // Round-robin pointer advance wraps at NCH, not at 2**SELW.
    assign rr_next = (int'(cand) == NCH - 1) ? '0 : cand + SELW'(1);

    always_comb begin
        din_ready = '0;
        if (grant) begin
            din_ready[cand] = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Arbiter FSM and registered output stage
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register
        // samples the values from before this edge regardless of order.
        if (rst) begin
            // NOTE: the data registers are reset too. dout and dout_ch are
            // visible outputs and must not carry stale values after reset.
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_ch    <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
        end else if (grant) begin
            dout       <= ch_data[cand];
            dout_ch    <= cand;
            dout_last  <= din_last[cand];
            dout_valid <= 1'b1;
            if (din_last[cand]) begin
                state  <= IDLE;
                rr_ptr <= rr_next;
            end else begin
                state   <= LOCKED;
                lock_ch <= cand;
            end
        end else if (dout_ready) begin
            // Drained with nothing to replace it. The data fields keep their
            // last value.
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_n
//
// Directed bench for mux_arb_n with DLEN = 32 and NCH = 4. Each stimulus
// section pushes its hand-computed output beats into exp_q. A separate monitor
// pops a beat and compares it whenever the DUT hands one downstream
// (dout_valid & dout_ready). Cycle-specific checks of din_ready and the output
// registers are made inline by the stimulus.
// Inputs change 1 time unit after a rising edge. Checks are made on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mux_arb_n;

    localparam int DLEN = 32;
    localparam int NCH  = 4;
    localparam int SELW = 2;

    // Expected dout_ch sequence for the round-robin section.
    localparam int RR_SEQ [8] = '{0, 1, 2, 3, 0, 2, 3, 0};

    // Packet-lock table, one entry per cycle:
    //   ch1 valid, ch1 last, and the expected din_ready.
    localparam logic [5:0] PK_V1 = 6'b011001;
    localparam logic [5:0] PK_L1 = 6'b010000;
    localparam logic [3:0] PK_RDY [6] = '{4'b0010, 4'b0000, 4'b0000,
                                          4'b0010, 4'b0010, 4'b0100};

    typedef struct packed {
        logic            last;
        logic [SELW-1:0] ch;
        logic [DLEN-1:0] data;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH*DLEN-1:0] din;
    logic [NCH-1:0]      din_valid;
    logic [NCH-1:0]      din_last;
    logic [NCH-1:0]      din_ready;
    logic                mode;
    logic [SELW-1:0]     sel;
    logic [DLEN-1:0]     dout;
    logic [SELW-1:0]     dout_ch;
    logic                dout_last;
    logic                dout_valid;
    logic                dout_ready;

    beat_t exp_q [$];
    beat_t mon_exp;
    int    checks = 0;
    int    errors = 0;

    mux_arb_n #(.DLEN(DLEN), .NCH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .mode       (mode),
        .sel        (sel),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic [DLEN-1:0] d);
        din[i*DLEN +: DLEN] = d;
    endtask

    task automatic push(input int ch, input logic [DLEN-1:0] d, input logic l);
        exp_q.push_back(beat_t'{last: l, ch: SELW'(ch), data: d});
    endtask

    // Scoreboard monitor: compares each beat handed downstream.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("ready_onehot", 64'($onehot0(din_ready)), 64'(1));
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got ch=%0d data=%h with no expected beat (t=%0t)",
                             dout_ch, dout, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_beat", 64'({dout_last, dout_ch, dout}), 64'(mon_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   n;
        int   c;
        int   beat;

        // ---------------- reset with every channel valid ----------------
        rst        = 1'b1;
        mode       = 1'b1;
        sel        = '0;
        din_valid  = '1;
        din_last   = '1;
        dout_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, 32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 8; i++) push(RR_SEQ[i], 32'hA5A5_0000 + 32'(RR_SEQ[i]), 1'b1);

        repeat (2) begin
            @(negedge clk);
            check("rst_dout_valid", 64'(dout_valid), 64'(0));
            check("rst_dout", 64'(dout), 64'(0));
            check("rst_din_ready", 64'(din_ready), 64'(0));
        end
        #1 rst = 1'b0;
        #1 check("rr_first_grant", 64'(din_ready), 64'h1);

        // ---------------- round-robin fairness ----------------
        repeat (5) @(posedge clk);
        #1 din_valid = 4'b1101;
        repeat (3) @(posedge clk);
        #1 din_valid = '0;

        // ---------------- direct select, channel 2 streaming ----------------
        @(posedge clk); #1;
        mode      = 1'b0;
        sel       = 2'd2;
        din_valid = '1;
        din_last  = '1;
        for (int b = 0; b < 3; b++) begin
            set_ch(2, 32'hA5A5_0002 + 32'(b << 4));
            push(2, 32'hA5A5_0002 + 32'(b << 4), 1'b1);
            @(negedge clk);
            check("direct_ready", 64'(din_ready), 64'h4);
            @(posedge clk); #1;
        end
        din_valid = '0;

        // ---------------- backpressure on a single-beat stream ----------------
        @(posedge clk); #1;
        sel = 2'd0;
        for (int i = 0; i < 5; i++) push(0, 32'hB000_0000 + 32'(i), 1'b1);
        n = 0;
        c = 0;
        while (n < 5 && c < 20) begin
            set_ch(0, 32'hB000_0000 + 32'(n));
            din_valid  = 4'b0001;
            dout_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                check("bp_ready", 64'(din_ready), 64'h0);
                check("bp_dout", 64'(dout), 64'hB000_0001);
                check("bp_ch", 64'(dout_ch), 64'h0);
            end
            acc = din_ready[0];
            @(posedge clk); #1;
            if (acc) n++;
            c++;
        end
        check("bp_beats_sent", 64'(n), 64'(5));
        din_valid  = '0;
        dout_ready = 1'b1;

        // ---------------- packet lock: ch1 3-beat packet vs ch2 ----------------
        @(posedge clk); #1;
        mode     = 1'b1;
        din_last = '1;
        set_ch(2, 32'hC2C2_0002);
        push(1, 32'h1111_0001, 1'b0);
        push(1, 32'h1111_0002, 1'b0);
        push(1, 32'h1111_0003, 1'b1);
        push(2, 32'hC2C2_0002, 1'b1);
        beat = 1;
        for (int k = 0; k < 6; k++) begin
            // Direct select of ch2 from cycle 1 on must not break the lock.
            if (k == 1) begin
                mode = 1'b0;
                sel  = 2'd2;
            end
            din_valid   = {1'b0, 1'b1, PK_V1[k], 1'b0};
            din_last[1] = PK_L1[k];
            set_ch(1, 32'h1111_0000 + 32'(beat));
            @(negedge clk);
            check("pkt_ready", 64'(din_ready), 64'(PK_RDY[k]));
            acc = din_ready[1];
            @(posedge clk); #1;
            if (acc) beat++;
        end
        din_valid = '0;
        din_last  = '1;

        // ---------------- reset in the middle of a ch3 packet ----------------
        @(posedge clk); #1;
        mode       = 1'b1;
        din_valid  = 4'b1000;
        din_last   = '0;
        dout_ready = 1'b0;
        set_ch(3, 32'hD3D3_0003);
        @(negedge clk);
        check("rstpkt_grant", 64'(din_ready), 64'h8);
        @(posedge clk); #1;
        rst       = 1'b1;
        din_valid = 4'b1001;
        @(negedge clk);
        check("rstpkt_ready_in_rst", 64'(din_ready), 64'h0);
        check("rstpkt_held_valid", 64'(dout_valid), 64'(1));
        check("rstpkt_held_dout", 64'(dout), 64'hD3D3_0003);
        @(posedge clk); #1;
        rst        = 1'b0;
        dout_ready = 1'b1;
        din_last   = '1;
        set_ch(0, 32'hA5A5_0000);
        push(0, 32'hA5A5_0000, 1'b1);
        @(negedge clk);
        check("rstpkt_valid", 64'(dout_valid), 64'(0));
        check("rstpkt_dout", 64'(dout), 64'h0);
        check("rstpkt_next_grant", 64'(din_ready), 64'h1);
        @(posedge clk); #1;
        din_valid = '0;

        // ---------------- drain and summarise ----------------
        repeat (3) @(negedge clk);
        #1 check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
